// File: rtl/viterbi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// viterbi_frame_ctrl
//
// This block generates BER test traffic for a loop made of a convolutional
// encoder, a channel and a Viterbi decoder. It sends PRBS payload frames to
// the encoder. After each payload it adds zero tail bits to flush the
// encoder trellis, and it puts idle gaps between frames. It checks the
// decoder output against a copy of the transmitted bits that is delayed to
// match the decoder latency, and it counts bit errors and frame errors.
//
// Parameters
//   FRAME_LEN  payload bits per frame (>=1)
//   TAIL       zero flush bits after each payload (>=0)
//   GAP        idle cycles between consecutive frames (>=0)
//   DEC_LAT    cycles from enc_data_o to the matching dec_data_i bit (1..64)
//   SEED       LFSR seed (non-zero)
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   start_i         run request, sampled only while idle
//   abort_i         ends the run at the next edge, in any state
//   nframes_i       frames per run, 0 = continuous; latched on start
//   enc_data_o      bit to the encoder (registered)
//   enc_enable_o    encoder enable (registered)
//   dec_data_i      decoded bit from the Viterbi decoder
//   busy_o          high in every state except IDLE
//   done_o          one-cycle pulse when a run completes normally
//   frame_ct_o      frames fully compared this run (saturating)
//   bit_err_ct_o    payload bit mismatches this run (saturating)
//   frame_err_ct_o  frames with at least one mismatch (saturating)
//
// Control protocol: start_i is a level request. It is accepted at the first
// rising edge where the block is IDLE, start_i=1 and abort_i=0. While busy,
// start_i is ignored. abort_i takes priority over everything else. Once
// accepted, no acknowledge is needed because busy_o reports acceptance.
// ---------------------------------------------------------------------------
module viterbi_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned TAIL      = 2,
  parameter int unsigned GAP       = 4,
  parameter int unsigned DEC_LAT   = 12,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] nframes_i,
  output logic        enc_data_o,
  output logic        enc_enable_o,
  input  logic        dec_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] frame_ct_o,
  output logic [15:0] bit_err_ct_o,
  output logic [15:0] frame_err_ct_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_TAIL    = 3'd2,
    S_GAP     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  // Terminal counts for the per-state cycle counter. When TAIL or GAP is 0,
  // the matching state is never entered, so its terminal count does not
  // matter.
  localparam logic [15:0] FL_M1 = 16'(FRAME_LEN - 1);
  localparam logic [15:0] TL_M1 = (TAIL > 0) ? 16'(TAIL - 1) : 16'd0;
  localparam logic [15:0] GP_M1 = (GAP > 0) ? 16'(GAP - 1) : 16'd0;
  localparam logic [15:0] DL_M1 = 16'(DEC_LAT - 1);

  // Fibonacci LFSR. It shifts right, bit 0 is the output, and the feedback
  // enters at bit 15.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [15:0]        cnt_q,       cnt_d;
  logic [15:0]        lfsr_q,      lfsr_d;
  logic [15:0]        frame_idx_q, frame_idx_d;
  logic [15:0]        nframes_q,   nframes_d;
  logic               enc_data_q,  enc_data_d;
  logic               enc_en_q,    enc_en_d;
  logic               chk_q,       chk_d;
  logic               last_q,      last_d;
  logic               done_q,      done_d;
  logic               err_flag_q,  err_flag_d;
  logic [15:0]        frame_ct_q,  frame_ct_d;
  logic [15:0]        bit_err_q,   bit_err_d;
  logic [15:0]        frame_err_q, frame_err_d;
  logic [DEC_LAT-1:0] dl_bit_q,    dl_bit_d;
  logic [DEC_LAT-1:0] dl_chk_q,    dl_chk_d;
  logic [DEC_LAT-1:0] dl_last_q,   dl_last_d;

  logic        dl_bit_out;
  logic        dl_chk_out;
  logic        dl_last_out;
  logic        mismatch;
  logic        last_frame;
  logic        tail_exit;
  logic        enter_payload;
  logic [15:0] payload_src;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    frame_idx_d   = frame_idx_q;
    nframes_d     = nframes_q;
    enc_data_d    = 1'b0;
    enc_en_d      = 1'b0;
    chk_d         = 1'b0;
    last_d        = 1'b0;
    done_d        = 1'b0;
    err_flag_d    = err_flag_q;
    frame_ct_d    = frame_ct_q;
    bit_err_d     = bit_err_q;
    frame_err_d   = frame_err_q;
    tail_exit     = 1'b0;
    enter_payload = 1'b0;
    payload_src   = lfsr_q;

    last_frame = (nframes_q != 16'd0) && ((frame_idx_q + 16'd1) == nframes_q);

    // The delay line captures whatever is on the encoder outputs in this
    // cycle. Entry k holds the bit driven k+1 cycles earlier, so the top
    // entry lines up with the decoder bit that arrives DEC_LAT cycles later.
    dl_bit_d     = dl_bit_q << 1;
    dl_bit_d[0]  = enc_data_q;
    dl_chk_d     = dl_chk_q << 1;
    dl_chk_d[0]  = chk_q;
    dl_last_d    = dl_last_q << 1;
    dl_last_d[0] = last_q;

    dl_bit_out  = dl_bit_q[DEC_LAT-1];
    dl_chk_out  = dl_chk_q[DEC_LAT-1];
    dl_last_out = dl_last_q[DEC_LAT-1];

    // Error accounting. The frame verdict uses the sticky flag together
    // with the current bit, so an error on the last bit still counts.
    mismatch = dl_chk_out && (dec_data_i != dl_bit_out);
    if (mismatch) begin
      bit_err_d  = sat_inc(bit_err_q);
      err_flag_d = 1'b1;
    end
    if (dl_chk_out && dl_last_out) begin
      frame_ct_d = sat_inc(frame_ct_q);
      if (err_flag_q || mismatch) begin
        frame_err_d = sat_inc(frame_err_q);
      end
      err_flag_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          nframes_d     = nframes_i;
          frame_idx_d   = 16'd0;
          frame_ct_d    = 16'd0;
          bit_err_d     = 16'd0;
          frame_err_d   = 16'd0;
          err_flag_d    = 1'b0;
          enter_payload = 1'b1;
          payload_src   = SEED;
        end
      end

      S_PAYLOAD: begin
        if (cnt_q == FL_M1) begin
          if (TAIL > 0) begin
            state_d  = S_TAIL;
            cnt_d    = 16'd0;
            enc_en_d = 1'b1;
          end else begin
            tail_exit = 1'b1;
          end
        end else begin
          cnt_d      = cnt_q + 16'd1;
          enc_en_d   = 1'b1;
          enc_data_d = lfsr_q[0];
          lfsr_d     = lfsr_step(lfsr_q);
          chk_d      = 1'b1;
          last_d     = ((cnt_q + 16'd1) == FL_M1);
        end
      end

      S_TAIL: begin
        if (cnt_q == TL_M1) begin
          tail_exit = 1'b1;
        end else begin
          cnt_d    = cnt_q + 16'd1;
          enc_en_d = 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == GP_M1) begin
          enter_payload = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_DRAIN: begin
        if (cnt_q == DL_M1) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    // End of a frame body: a bounded run drains after its last frame, and
    // any other frame goes on to the gap or straight to the next payload.
    if (tail_exit) begin
      frame_idx_d = frame_idx_q + 16'd1;
      if (last_frame) begin
        state_d = S_DRAIN;
        cnt_d   = 16'd0;
      end else if (GAP > 0) begin
        state_d = S_GAP;
        cnt_d   = 16'd0;
      end else begin
        enter_payload = 1'b1;
      end
    end

    // The first payload bit is registered on the entry edge. The LFSR
    // therefore always holds the next bit to be sent.
    if (enter_payload) begin
      state_d    = S_PAYLOAD;
      cnt_d      = 16'd0;
      enc_en_d   = 1'b1;
      enc_data_d = payload_src[0];
      lfsr_d     = lfsr_step(payload_src);
      chk_d      = 1'b1;
      last_d     = (FRAME_LEN == 1);
    end

    // Abort: return to IDLE quietly. Counters freeze at their current values
    // and in-flight bits are disqualified from checking.
    if (abort_i) begin
      state_d     = S_IDLE;
      cnt_d       = 16'd0;
      lfsr_d      = lfsr_q;
      frame_idx_d = frame_idx_q;
      nframes_d   = nframes_q;
      enc_data_d  = 1'b0;
      enc_en_d    = 1'b0;
      chk_d       = 1'b0;
      last_d      = 1'b0;
      done_d      = 1'b0;
      err_flag_d  = 1'b0;
      frame_ct_d  = frame_ct_q;
      bit_err_d   = bit_err_q;
      frame_err_d = frame_err_q;
      dl_chk_d    = '0;
      dl_last_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      lfsr_q      <= SEED;
      frame_idx_q <= 16'd0;
      nframes_q   <= 16'd0;
      enc_data_q  <= 1'b0;
      enc_en_q    <= 1'b0;
      chk_q       <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      frame_ct_q  <= 16'd0;
      bit_err_q   <= 16'd0;
      frame_err_q <= 16'd0;
      dl_bit_q    <= '0;
      dl_chk_q    <= '0;
      dl_last_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      frame_idx_q <= frame_idx_d;
      nframes_q   <= nframes_d;
      enc_data_q  <= enc_data_d;
      enc_en_q    <= enc_en_d;
      chk_q       <= chk_d;
      last_q      <= last_d;
      done_q      <= done_d;
      err_flag_q  <= err_flag_d;
      frame_ct_q  <= frame_ct_d;
      bit_err_q   <= bit_err_d;
      frame_err_q <= frame_err_d;
      dl_bit_q    <= dl_bit_d;
      dl_chk_q    <= dl_chk_d;
      dl_last_q   <= dl_last_d;
    end
  end

  assign enc_data_o     = enc_data_q;
  assign enc_enable_o   = enc_en_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign frame_ct_o     = frame_ct_q;
  assign bit_err_ct_o   = bit_err_q;
  assign frame_err_ct_o = frame_err_q;

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Test-traffic sequencer for the convolutional-encoder → channel → Viterbi-decoder loop. It generates PRBS payload frames and inserts zero tail bits to flush the encoder trellis. It drives the encoder enable/data and compares decoder output against a latency-matched copy of the transmitted payload. It sits upstream of the encoder and alongside the decoder output, and reports bit-error and frame-error counts for BER runs.

## Interface
- FRAME_LEN, 16: payload bits per frame (≥1)
- TAIL, 2: zero flush bits after each payload (constraint length − 1; ≥0)
- GAP, 4: idle cycles (enable low) between consecutive frames (≥0)
- DEC_LAT, 12: cycles from enc_data_o to the matching dec_data_i bit (1..64)
- SEED, 16'hACE1: LFSR seed (non-zero)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  run request; sampled only in IDLE
- abort_i  in  1  terminate run; honoured in any state
- nframes_i  in  16  frames per run; 0 = continuous until abort; latched on start
- enc_data_o  out  1  bit to encoder (registered)
- enc_enable_o  out  1  encoder enable (registered)
- dec_data_i  in  1  decoded bit from Viterbi decoder
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at normal run completion
- frame_ct_o  out  16  frames fully compared this run
- bit_err_ct_o  out  16  payload bit mismatches this run
- frame_err_ct_o  out  16  frames with ≥1 mismatch this run

## Operation
- Reset: state IDLE, LFSR=SEED, delay line cleared (all valid flags 0). All outputs and counters are 0.
- States:
  - IDLE → PAYLOAD on start_i & !abort_i. Start acceptance loads the LFSR with SEED, clears the three counters, latches nframes_i, and zeroes the frame index.
  - PAYLOAD: FRAME_LEN cycles. enc_enable_o=1 and enc_data_o=lfsr[0]. The LFSR advances once per payload bit: next = {lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5], lfsr[15:1]}. Then go to TAIL, or to the TAIL-exit target directly if TAIL=0.
  - TAIL: TAIL cycles with enc_enable_o=1 and enc_data_o=0. The LFSR holds.
  - TAIL exit: if this is the last frame (index+1 == latched nframes, nframes≠0), go to DRAIN. Otherwise go to GAP, or to PAYLOAD if GAP=0.
  - GAP: GAP cycles with enc_enable_o=0 and enc_data_o=0, then PAYLOAD.
  - DRAIN: DEC_LAT cycles with enc_enable_o=0, then IDLE with done_o=1 for one cycle.
- Delay line: DEC_LAT deep. Each entry holds {bit, chk, last}. It is written every cycle with the bit on enc_data_o:
  - chk=1 for payload bits only; chk=0 for tail and gap bits.
  - last=1 on the final payload bit of a frame.
- Compare at the delay-line output when chk=1:
  - dec_data_i ≠ bit → bit_err_ct_o += 1 and set the sticky per-frame error flag.
  - When last=1: frame_ct_o += 1; frame_err_ct_o += 1 if the flag (including the current bit) is set; clear the flag.
- All counters saturate at 16'hFFFF. No wrap.
- Abort: next cycle state=IDLE, enc_enable_o=0, enc_data_o=0, delay-line chk/last flags cleared. Counters hold. No done_o pulse.
- start_i while busy_o=1 is ignored. start_i & abort_i together in IDLE: abort wins, and the block stays IDLE.
- Continuous mode (nframes=0): never enters DRAIN. The run ends only by abort.

## Timing
- Start accepted at edge 0. The first payload bit is on enc_data_o/enc_enable_o in cycle 1.
- Frame k (non-last) occupies FRAME_LEN+TAIL+GAP cycles. The last frame omits GAP.
- The bit driven in cycle t is compared against dec_data_i sampled at the edge ending cycle t+DEC_LAT.
- Counter updates are visible the cycle after the compare edge.
- done_o is asserted in the first IDLE cycle, the same cycle busy_o falls. Final counts are stable when done_o=1.
- rst asserted mid-run: immediate return to reset values, regardless of clock.

## Test plan
- Ideal loopback: dec_data_i = enc_data_o delayed DEC_LAT; defaults, nframes=3.
  - Payload cycles 1–16, 23–38, 45–60.
  - done_o in cycle 75 (drain 63–74); busy_o low from cycle 75.
  - frame_ct=3, bit_err=0, frame_err=0.
- Single flip: invert dec_data_i at the compare slot of frame 1, payload bit 5 → bit_err=1, frame_err=1, frame_ct=3.
- Tail/gap flips: invert dec_data_i only in tail and gap compare slots → all error counts 0.
- PRBS check: the first 16 payload bits after start equal the LFSR sequence from SEED 16'hACE1. A second start reproduces the identical sequence.
- Continuous mode: nframes=0, ideal loopback, abort_i after frame_ct reaches 5.
  - IDLE next cycle, no done_o, frame_ct holds at 5.
  - A start_i pulse while busy has no effect.
- Reset mid-run: assert rst in cycle 30 → all outputs 0 immediately, IDLE. A subsequent start behaves exactly as the first run.
